// File: rtl/bsg_arb_pkg.sv
// Shared arbiter types and sizing helpers.
package bsg_arb_pkg;

  localparam int age_width_gp  = 4;
  localparam int max_inputs_gp = 32;

  typedef logic [age_width_gp-1:0] age_t;

  function automatic int lg_f(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_age_arb_tracked_if.sv
// Request/grant bundle between requesters and the age-tracked arbiter.
interface bsg_age_arb_tracked_if #(
  parameter int inputs_p    = 4,
  parameter int age_width_p = 4
);
  localparam int lg_inputs_lp = bsg_arb_pkg::lg_f(inputs_p);

  logic [inputs_p-1:0]             reqs_i;
  logic                            ready_i;
  logic [inputs_p-1:0]             grants_o;
  logic                            grant_v_o;
  logic [lg_inputs_lp-1:0]         grant_id_o;
  logic [inputs_p*age_width_p-1:0] ages_o;

  modport slave (
    input  reqs_i, ready_i,
    output grants_o, grant_v_o, grant_id_o, ages_o
  );

  modport master (
    output reqs_i, ready_i,
    input  grants_o, grant_v_o, grant_id_o, ages_o
  );

endinterface

// File: rtl/bsg_age_max_select.sv
// Combinational pick of the oldest requester; ties go to the first index after i_last.
// Zero latency; i_en low forces an empty grant.
module bsg_age_max_select
  import bsg_arb_pkg::*;
#(
  parameter int inputs_p    = 4,
  parameter int age_width_p = 4,
  localparam int lg_inputs_lp = lg_f(inputs_p)
) (
  input  logic [inputs_p-1:0]             i_reqs,
  input  logic                            i_en,
  input  logic [inputs_p*age_width_p-1:0] i_ages,
  input  logic [lg_inputs_lp-1:0]         i_last,
  output logic [inputs_p-1:0]             o_grants,
  output logic [lg_inputs_lp-1:0]         o_grant_id
);

  logic [age_width_p-1:0]  w_ages [inputs_p];
  logic [lg_inputs_lp:0]   w_dist [inputs_p];
  logic                    w_found;
  logic [age_width_p-1:0]  w_best_age;
  logic [lg_inputs_lp:0]   w_best_dist;

  for (genvar j = 0; j < inputs_p; j++) begin : g_unpack
    assign w_ages[j] = i_ages[j*age_width_p +: age_width_p];
  end

  // Circular distance from the slot just after the last winner; smaller wins a tie.
  always_comb begin
    for (int j = 0; j < inputs_p; j++) begin
      if (j > int'(i_last)) begin
        w_dist[j] = (lg_inputs_lp+1)'(j - int'(i_last) - 1);
      end else begin
        w_dist[j] = (lg_inputs_lp+1)'(j + inputs_p - int'(i_last) - 1);
      end
    end
  end

  always_comb begin
    o_grants    = '0;
    o_grant_id  = '0;
    w_found     = 1'b0;
    w_best_age  = '0;
    w_best_dist = '0;
    for (int j = 0; j < inputs_p; j++) begin
      if (i_en && i_reqs[j] &&
          (!w_found || (w_ages[j] > w_best_age) ||
           ((w_ages[j] == w_best_age) && (w_dist[j] < w_best_dist)))) begin
        w_found     = 1'b1;
        w_best_age  = w_ages[j];
        w_best_dist = w_dist[j];
        o_grants    = '0;
        o_grants[j] = 1'b1;
        o_grant_id  = lg_inputs_lp'(j);
      end
    end
  end

endmodule

// File: rtl/bsg_age_arb_tracked.sv
// Age-based arbiter: grants the oldest waiting requester, round-robin on ties, zero-cycle grant.
// Ages saturate rather than wrap; ready_i low or reset suppresses all grants.
module bsg_age_arb_tracked
  import bsg_arb_pkg::*;
#(
  parameter int inputs_p    = 4,
  parameter int age_width_p = 4,
  localparam int lg_inputs_lp = lg_f(inputs_p)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  bsg_age_arb_tracked_if.slave   arb_if
);

  logic [age_width_p-1:0]          r_age [inputs_p];
  logic [lg_inputs_lp-1:0]         r_last;
  logic [inputs_p*age_width_p-1:0] w_ages_flat;
  logic [inputs_p-1:0]             w_grants;
  logic [lg_inputs_lp-1:0]         w_grant_id;
  logic                            w_grant_v;
  logic                            w_en;

  assign w_en = arb_if.ready_i & ~reset_i;

  for (genvar i = 0; i < inputs_p; i++) begin : g_flat
    assign w_ages_flat[i*age_width_p +: age_width_p] = r_age[i];
  end

  bsg_age_max_select #(
    .inputs_p    (inputs_p),
    .age_width_p (age_width_p)
  ) u_sel (
    .i_reqs     (arb_if.reqs_i),
    .i_en       (w_en),
    .i_ages     (w_ages_flat),
    .i_last     (r_last),
    .o_grants   (w_grants),
    .o_grant_id (w_grant_id)
  );

  assign w_grant_v = |w_grants;

  // last starts at the top index so index 0 wins the first tie after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < inputs_p; i++) begin
        r_age[i] <= '0;
      end
      r_last <= lg_inputs_lp'(inputs_p - 1);
    end else begin
      for (int i = 0; i < inputs_p; i++) begin
        if (!arb_if.reqs_i[i] || w_grants[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != {age_width_p{1'b1}}) begin
          r_age[i] <= r_age[i] + 1'b1;
        end
      end
      if (w_grant_v) begin
        r_last <= w_grant_id;
      end
    end
  end

  assign arb_if.grants_o   = w_grants;
  assign arb_if.grant_v_o  = w_grant_v;
  assign arb_if.grant_id_o = w_grant_id;
  assign arb_if.ages_o     = reset_i ? '0 : w_ages_flat;

  a_onehot: assert property (@(posedge clk_i) $onehot0(w_grants));
  a_id_match: assert property (@(posedge clk_i) !w_grant_v || w_grants[w_grant_id]);

endmodule

// File: tb/tb_bsg_age_arb_tracked.sv
// Directed and randomized checks of bsg_age_arb_tracked with 4 requesters and 3-bit ages.
module tb_bsg_age_arb_tracked;
  localparam int N  = 4;
  localparam int AW = 3;
  localparam int AMAX = (1 << AW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bsg_age_arb_tracked_if #(.inputs_p(N), .age_width_p(AW)) arb_if();

  bsg_age_arb_tracked #(.inputs_p(N), .age_width_p(AW)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .arb_if  (arb_if)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic rd);
    arb_if.reqs_i  = r;
    arb_if.ready_i = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int m_age [N];
  int m_last;
  int wait_cnt [N];
  int max_wait;

  initial begin
    logic [N-1:0] r;
    logic rd;
    logic [N-1:0] exp_g;
    int exp_id, maxa, idx;
    logic [31:0] exp_ages;

    arb_if.reqs_i  = 4'b1111;
    arb_if.ready_i = 1'b1;
    #1;
    check_eq("rst_grants", arb_if.grants_o, 0);
    check_eq("rst_gv", arb_if.grant_v_o, 0);
    check_eq("rst_id", arb_if.grant_id_o, 0);
    check_eq("rst_ages", arb_if.ages_o, 0);
    tick();
    tick();

    // All four wait with ready low: ages saturate at 7, then rotate 0,1,2,3.
    reset = 1'b0;
    drive(4'b1111, 1'b0);
    repeat (10) tick();
    check_eq("sat_ages", arb_if.ages_o, 32'hFFF);
    check_eq("sat_nogrant", arb_if.grants_o, 0);
    drive(4'b1111, 1'b1);
    check_eq("rr_g0", arb_if.grants_o, 4'b0001);
    tick();
    check_eq("rr_g1", arb_if.grants_o, 4'b0010);
    tick();
    check_eq("rr_g2", arb_if.grants_o, 4'b0100);
    tick();
    check_eq("rr_g3", arb_if.grants_o, 4'b1000);
    check_eq("rr_id3", arb_if.grant_id_o, 3);
    check_eq("rr_ages3", arb_if.ages_o, 32'hE0A);
    tick();
    check_eq("rr_ages4", arb_if.ages_o, 32'h053);
    check_eq("rr_g4", arb_if.grants_o, 4'b0001);
    drive(4'b0000, 1'b0);
    tick();

    // Single requester, same-cycle grant.
    drive(4'b0100, 1'b1);
    check_eq("one_g", arb_if.grants_o, 4'b0100);
    check_eq("one_gv", arb_if.grant_v_o, 1);
    check_eq("one_id", arb_if.grant_id_o, 2);
    tick();

    // req0 from cycle 0, req3 from cycle 2, ready at cycle 4.
    drive(4'b0001, 1'b0); tick();
    drive(4'b0001, 1'b0); tick();
    drive(4'b1001, 1'b0); tick();
    drive(4'b1001, 1'b0); tick();
    drive(4'b1001, 1'b1);
    check_eq("age_ages", arb_if.ages_o, 32'h404);
    check_eq("age_g", arb_if.grants_o, 4'b0001);
    check_eq("age_id", arb_if.grant_id_o, 0);
    tick();
    drive(4'b0000, 1'b0);
    tick();

    // req1 loses its age after dropping; req2 with age 2 wins.
    repeat (5) begin
      drive(4'b0010, 1'b0);
      tick();
    end
    drive(4'b0100, 1'b0);
    check_eq("drop_age5", arb_if.ages_o, 32'h028);
    tick();
    drive(4'b0100, 1'b0);
    tick();
    drive(4'b0110, 1'b1);
    check_eq("drop_ages", arb_if.ages_o, 32'h080);
    check_eq("drop_g", arb_if.grants_o, 4'b0100);
    tick();
    drive(4'b0010, 1'b1);
    check_eq("indep_ages", arb_if.ages_o, 32'h008);
    check_eq("indep_g", arb_if.grants_o, 4'b0010);
    tick();
    drive(4'b0000, 1'b0);
    tick();

    // Mid-operation reset pulse.
    drive(4'b1111, 1'b0);
    repeat (3) tick();
    check_eq("pre_rst_ages", arb_if.ages_o, 32'h6DB);
    reset = 1'b1;
    drive(4'b1111, 1'b1);
    check_eq("mid_rst_g", arb_if.grants_o, 0);
    check_eq("mid_rst_gv", arb_if.grant_v_o, 0);
    check_eq("mid_rst_ages", arb_if.ages_o, 0);
    tick();
    reset = 1'b0;
    drive(4'b1111, 1'b1);
    check_eq("post_rst_ages", arb_if.ages_o, 0);
    check_eq("post_rst_g", arb_if.grants_o, 4'b0001);
    tick();
    drive(4'b0000, 1'b0);
    tick();

    // Randomized run against a reference model.
    reset = 1'b1;
    drive(4'b0000, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_age[i]    = 0;
      wait_cnt[i] = 0;
    end
    m_last   = N - 1;
    max_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      r  = N'($urandom_range(0, (1 << N) - 1));
      rd = ($urandom_range(0, 3) != 0);
      drive(r, rd);

      exp_g  = '0;
      exp_id = 0;
      if (rd && (r != 0)) begin
        maxa = -1;
        for (int i = 0; i < N; i++) begin
          if (r[i] && m_age[i] > maxa) maxa = m_age[i];
        end
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (exp_g == 0 && r[idx] && m_age[idx] == maxa) begin
            exp_g[idx] = 1'b1;
            exp_id     = idx;
          end
        end
      end
      exp_ages = '0;
      for (int i = 0; i < N; i++) begin
        exp_ages |= 32'(m_age[i]) << (i * AW);
      end

      check_eq("rnd_g", arb_if.grants_o, exp_g);
      check_eq("rnd_gv", arb_if.grant_v_o, (exp_g != 0));
      check_eq("rnd_id", arb_if.grant_id_o, exp_id);
      check_eq("rnd_ages", arb_if.ages_o, exp_ages);
      check_eq("rnd_onehot", 32'($onehot0(arb_if.grants_o)), 1);

      for (int i = 0; i < N; i++) begin
        if (!r[i] || arb_if.grants_o[i]) begin
          wait_cnt[i] = 0;
        end else if (rd) begin
          wait_cnt[i]++;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        if (!r[i] || exp_g[i]) m_age[i] = 0;
        else if (m_age[i] < AMAX) m_age[i]++;
      end
      if (exp_g != 0) m_last = exp_id;
      tick();
    end
    check_eq("max_wait_le_32", (max_wait <= 32), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bsg_age_arb_tracked.md
BSG_AGE_ARB_TRACKED -- requirements
Module: bsg_age_arb_tracked

Interface
REQ-001 The block SHALL have parameter inputs_p, default 4, giving the number of requesters; legal range 1..32.
REQ-002 The block SHALL have parameter age_width_p, default 4, giving the width of each saturating wait-age counter; legal values are 1 or more.
REQ-003 The block SHALL have parameter lg_inputs_lp, derived as max(1, clog2(inputs_p)), and it SHALL NOT be overridden.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Port clk_i, input, width 1, SHALL be the block clock.
REQ-006 Port reset_i, input, width 1, SHALL be the synchronous active-high reset.
REQ-007 Port reqs_i, input, width inputs_p, SHALL carry the per-requester request bits.
REQ-008 Port ready_i, input, width 1, SHALL indicate that the downstream can accept one grant this cycle.
REQ-009 Port grants_o, output, width inputs_p, SHALL be the one-hot grant (all zeros when no grant is issued).
REQ-010 Port grant_v_o, output, width 1, SHALL equal the OR-reduction of grants_o.
REQ-011 Port grant_id_o, output, width lg_inputs_lp, SHALL give the binary index of the granted requester, and SHALL be 0 when grant_v_o=0.
REQ-012 Port ages_o, output, width inputs_p*age_width_p, SHALL expose the current counter values for debug.

Function
REQ-013 The block SHALL hold one registered age counter age_q[i] per requester, plus a registered last-grant pointer last_q of width lg_inputs_lp.
REQ-014 Grant selection SHALL be combinational from reqs_i, ready_i, age_q and last_q, giving zero-cycle latency from request to grant.
REQ-015 When ready_i=0, when reqs_i is all zeros, or when reset_i=1, grants_o SHALL be all zeros.
REQ-016 Otherwise, exactly one grant SHALL be issued, to the requester with reqs_i set and the maximum age_q.
REQ-017 A tie on maximum age SHALL be broken round-robin: the first tied index in circular order starting at last_q+1 (mod inputs_p) wins.
REQ-018 Each age_q[i] SHALL be updated every cycle according to REQ-019 through REQ-021.
REQ-019 Age update: if reqs_i[i]=0 or grants_o[i]=1, age_q[i] SHALL become 0 next cycle.
REQ-020 Age update: otherwise, if age_q[i] is below 2^age_width_p-1, age_q[i] SHALL increment by 1.
REQ-021 Age update: otherwise (counter at maximum), age_q[i] SHALL hold and SHALL NOT wrap.
REQ-022 last_q SHALL load grant_id_o on every cycle in which grant_v_o=1, and SHALL hold otherwise.
REQ-023 A requester that drops its request before being granted SHALL lose its accumulated age; on reassertion it restarts at 0.
REQ-024 A new request and a grant to a different requester in the same cycle SHALL be handled independently: the new requester ages from 0 and the granted requester clears.
REQ-025 Starvation freedom: with ready_i held at 1, a continuously asserted request SHALL be granted within inputs_p*(2^age_width_p) cycles.
REQ-026 When inputs_p=1, grants_o SHALL equal ready_i AND reqs_i, the age counter SHALL still operate, and grant_id_o SHALL be 0.

Reset
REQ-027 While reset_i=1 at a rising clk_i edge, all age_q SHALL be set to 0 and last_q SHALL be set to inputs_p-1, so that index 0 wins the first tie.
REQ-028 A reset asserted mid-operation SHALL discard all ages in one cycle, with no partial-grant side effects.
REQ-029 All outputs SHALL be 0 during reset.

Structure
REQ-030 The age type width and a log2 helper function SHALL be placed in the shared package bsg_arb_pkg.
REQ-031 The maximum-age, round-robin-tie selection SHALL be a single combinational sub-module, bsg_age_max_select, instantiated once.
REQ-032 The age counters and last_q SHALL reside in the top level.
REQ-033 There SHALL be no latches, and grants_o SHALL be at most one-hot in all states, checked by assertion.

Verification (inputs_p=4, age_width_p=3)
REQ-034 Scenario: reqs_i=0100, ready_i=1 -> grants_o=0100, grant_v_o=1, grant_id_o=2 in the same cycle.
REQ-035 Scenario: req0 raised at cycle 0, req3 at cycle 2, ready_i=0 until cycle 4 -> at cycle 4 ages are 4 and 2, grants_o=0001.
REQ-036 Scenario: reqs_i=1111 with ready_i=0 for 10 cycles (all ages saturate at 7), then ready_i=1 held -> grants 0001, 0010, 0100, 1000 on consecutive cycles.
REQ-037 Scenario: req1 waits 5 cycles, drops for 1 cycle, then reasserts while req2 has age 2 -> grants_o=0100.
REQ-038 Scenario: ages nonzero, reset_i pulsed for 1 cycle -> grants_o=0 during reset; afterwards ages_o=0 and a 1111 request grants 0001.
REQ-039 Scenario: random reqs_i/ready_i for 10k cycles -> no requester waits longer than 32 cycles, and the one-hot and grant_v_o consistency checks always pass.
